// File: rtl/window_filter_pkg.sv
// window_filter_pkg: shared types and constants for the window filter.
// Holds the decision mode and FSM state enums and the hit counter width.
package window_filter_pkg;

    typedef enum logic [1:0] {
        MODE_AVG  = 2'b00,
        MODE_ALL  = 2'b01,
        MODE_RISE = 2'b10,
        MODE_RAW  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int HITS_W = 16;

endpackage

// File: rtl/window_filter_shreg.sv
// window_filter_shreg: DEPTH-deep delay line of {over-flag, sample}.
// Ports: clk, rst (async low), en (shift), clr (sync clear), d/d_flag in, old/old_flag = oldest entry.
module window_filter_shreg #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    input  logic         d_flag,
    output logic [W-1:0] old,
    output logic         old_flag
);

    logic [W:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (en) begin
            mem[0] <= {d_flag, d};
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    assign {old_flag, old} = mem[DEPTH-1];

endmodule

// File: rtl/window_filter.sv
// window_filter: sliding-window sum/average filter with a mode-selected 1-bit decision.
// Ports: clk, rst (async low), x_is_valid/x, flush, mode, thresh -> y, y_valid, avg, hits. Macro WINDOW_FILTER_STATS_EN enables hits.
module window_filter
    import window_filter_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_is_valid,
    input  logic [W-1:0]      x,
    input  logic              flush,
    input  logic [1:0]        mode,
    input  logic [W-1:0]      thresh,
    output logic              y,
    output logic              y_valid,
    output logic [W-1:0]      avg,
    output logic [HITS_W-1:0] hits
);

    localparam int L  = $clog2(DEPTH);
    localparam int SW = W + L;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [L-1:0]  FILL_LAST = L'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    // Flush wins over a coincident sample.
    logic accept;
    logic x_over;
    assign accept = x_is_valid & ~flush;
    assign x_over = x > thresh;

    logic [W-1:0] old_x;
    logic         old_f;

    window_filter_shreg #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .en       (accept),
        .clr      (flush),
        .d        (x),
        .d_flag   (x_over),
        .old      (old_x),
        .old_flag (old_f)
    );

    state_t        state;
    logic [L-1:0]  fill_cnt;
    logic          last_fill;

    assign last_fill = (state == ST_FILL) &&
                       (fill_cnt == FILL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
        end else if (flush) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
        end else if (accept && state == ST_FILL) begin
            if (last_fill) begin
                state    <= ST_RUN;
                fill_cnt <= '0;
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    logic [SW-1:0] sum;
    logic [CW-1:0] over_cnt;

    // Window slots start at zero, so subtracting the oldest is safe in FILL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum      <= '0;
            over_cnt <= '0;
        end else if (flush) begin
            sum      <= '0;
            over_cnt <= '0;
        end else if (accept) begin
            sum      <= sum + SW'(x) - SW'(old_x);
            over_cnt <= over_cnt + CW'(x_over)
                                 - CW'(old_f);
        end
    end

    // Controls captured with the sample, used one cycle later.
    logic         pend_v;
    logic         pend_raw;
    mode_t        pend_mode;
    logic [W-1:0] pend_thresh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v      <= 1'b0;
            pend_raw    <= 1'b0;
            pend_mode   <= MODE_AVG;
            pend_thresh <= '0;
        end else begin
            pend_v <= accept &&
                      (state == ST_RUN || last_fill ||
                       mode_t'(mode) == MODE_RAW);
            if (accept) begin
                pend_raw    <= x_over;
                pend_mode   <= mode_t'(mode);
                pend_thresh <= thresh;
            end
        end
    end

    logic [W-1:0] avg_next;
    logic         avg_gt;
    logic         prev;
    logic         y_next;

    assign avg_next = sum[SW-1:L];
    assign avg_gt   = avg_next > pend_thresh;

    always_comb begin
        y_next = 1'b0;
        unique case (pend_mode)
            MODE_AVG:  y_next = avg_gt;
            MODE_ALL:  y_next = (over_cnt == CNT_FULL);
            MODE_RISE: y_next = avg_gt && !prev;
            MODE_RAW:  y_next = pend_raw;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y       <= 1'b0;
            y_valid <= 1'b0;
            avg     <= '0;
            prev    <= 1'b0;
        end else if (flush) begin
            y_valid <= 1'b0;
            prev    <= 1'b0;
        end else begin
            y_valid <= pend_v;
            if (pend_v) begin
                y    <= y_next;
                avg  <= avg_next;
                prev <= avg_gt;
            end
        end
    end

`ifdef WINDOW_FILTER_STATS_EN
    logic [HITS_W-1:0] hits_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q <= '0;
        end else if (flush) begin
            hits_q <= '0;
        end else if (pend_v && y_next && !(&hits_q)) begin
            hits_q <= hits_q + 1'b1;
        end
    end

    assign hits = hits_q;
`else
    assign hits = '0;
`endif

endmodule

// File: tb/tb_window_filter.sv
// tb_window_filter: directed table plus randomized run against a queue-based model.
// Checks y, y_valid, avg and hits after every clock edge.
module tb_window_filter;

    localparam int W     = 4;
    localparam int DEPTH = 4;

`ifdef WINDOW_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         x_is_valid = 1'b0;
    logic [W-1:0] x = '0;
    logic         flush = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] thresh = 4'd5;
    logic         y;
    logic         y_valid;
    logic [W-1:0] avg;
    logic [15:0]  hits;

    window_filter #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_is_valid (x_is_valid),
        .x          (x),
        .flush      (flush),
        .mode       (mode),
        .thresh     (thresh),
        .y          (y),
        .y_valid    (y_valid),
        .avg        (avg),
        .hits       (hits)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     nm, $time, act, exp);
        end
    endtask

    // Reference model: the window as a queue of samples and entry flags.
    int mq[$];
    bit mf[$];
    bit m_pv, m_py, m_pcmp, m_prev;
    int m_pavg, m_hits;
    bit e_yv, e_y;
    int e_avg;

    task automatic model_reset();
        mq.delete();
        mf.delete();
        m_pv = 0; m_py = 0; m_pcmp = 0; m_prev = 0;
        m_pavg = 0; m_hits = 0;
        e_yv = 0; e_y = 0; e_avg = 0;
    endtask

    task automatic model_step(input bit v, input bit fl,
                              input logic [1:0] md,
                              input int xx, input int th);
        int s, o, a;
        bit cmp;
        if (fl) begin
            mq.delete();
            mf.delete();
            m_pv = 0; m_prev = 0; m_hits = 0;
            e_yv = 0;
            return;
        end
        e_yv = m_pv;
        if (m_pv) begin
            e_y = m_py;
            e_avg = m_pavg;
            m_prev = m_pcmp;
            if (m_py && STATS && m_hits < 65535)
                m_hits++;
        end
        m_pv = 0;
        if (v) begin
            if (mq.size() == DEPTH) begin
                void'(mq.pop_front());
                void'(mf.pop_front());
            end
            mq.push_back(xx);
            mf.push_back(xx > th);
            s = 0; o = 0;
            foreach (mq[i]) s += mq[i];
            foreach (mf[i]) o += int'(mf[i]);
            a = s / DEPTH;
            cmp = a > th;
            case (md)
                2'd0: m_py = cmp;
                2'd1: m_py = (o == DEPTH);
                2'd2: m_py = cmp && !m_prev;
                default: m_py = xx > th;
            endcase
            m_pv = (mq.size() == DEPTH) || md == 2'd3;
            m_pavg = a;
            m_pcmp = cmp;
        end
    endtask

    task automatic check_model();
        chk("model y_valid", 32'(y_valid), 32'(e_yv));
        chk("model y", 32'(y), 32'(e_y));
        chk("model avg", 32'(avg), 32'(e_avg));
        chk("model hits", 32'(hits), 32'(m_hits));
    endtask

    task automatic step(input bit v, input bit fl,
                        input logic [1:0] md,
                        input logic [3:0] xx,
                        input logic [3:0] th);
        @(negedge clk);
        x_is_valid = v;
        flush = fl;
        mode = md;
        x = xx;
        thresh = th;
        @(posedge clk);
        #1;
        model_step(v, fl, md, int'(xx), int'(th));
        check_model();
    endtask

    typedef struct {
        bit         v;
        bit         fl;
        logic [1:0] md;
        logic [3:0] x;
        bit         eyv;
        bit         ey;
        logic [3:0] eavg;
        int         eh;
    } vec_t;

    vec_t tbl[$];

    task automatic reset_pulse();
        step(bit'($urandom_range(0, 1)), 1'b0,
             2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), 4'd5);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async rst y_valid", 32'(y_valid), 0);
        chk("async rst y", 32'(y), 0);
        chk("async rst avg", 32'(avg), 0);
        chk("async rst hits", 32'(hits), 0);
        @(negedge clk);
        x_is_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        // Test plan sequence, thresh 5 throughout.
        tbl.push_back('{1,0,0, 5,0,0,0,0});
        tbl.push_back('{1,0,0, 7,0,0,0,0});
        tbl.push_back('{1,0,0, 4,0,0,0,0});
        tbl.push_back('{1,0,0, 8,0,0,0,0});
        tbl.push_back('{1,0,0,15,1,1,6,1});
        tbl.push_back('{1,0,0, 0,1,1,8,2});
        tbl.push_back('{1,0,0, 0,1,1,6,3});
        tbl.push_back('{0,0,0, 0,1,0,5,3});
        tbl.push_back('{0,0,0, 0,0,0,5,3});
        tbl.push_back('{0,1,0, 0,0,0,5,0});
        tbl.push_back('{1,0,1, 6,0,0,5,0});
        tbl.push_back('{1,0,1, 7,0,0,5,0});
        tbl.push_back('{1,0,1, 8,0,0,5,0});
        tbl.push_back('{1,0,1, 9,0,0,5,0});
        tbl.push_back('{1,0,1, 5,1,1,7,1});
        tbl.push_back('{1,0,1, 6,1,0,7,1});
        tbl.push_back('{0,0,1, 0,1,0,7,1});
        tbl.push_back('{0,1,2, 0,0,0,7,0});
        tbl.push_back('{1,0,2, 3,0,0,7,0});
        tbl.push_back('{1,0,2, 0,0,0,7,0});
        tbl.push_back('{1,0,2,13,0,0,7,0});
        tbl.push_back('{1,0,2, 0,0,0,7,0});
        tbl.push_back('{1,0,2,11,1,0,4,0});
        tbl.push_back('{1,0,2, 4,1,1,6,1});
        tbl.push_back('{1,0,2, 0,1,0,7,1});
        tbl.push_back('{1,0,2, 9,1,0,3,1});
        tbl.push_back('{0,0,2, 0,1,1,6,2});
        tbl.push_back('{0,0,2, 0,0,1,6,2});
        tbl.push_back('{0,0,2, 0,0,1,6,2});
        tbl.push_back('{1,1,0, 9,0,1,6,0});
        tbl.push_back('{1,0,0, 1,0,1,6,0});
        tbl.push_back('{1,0,0, 1,0,1,6,0});
        tbl.push_back('{1,0,0, 1,0,1,6,0});
        tbl.push_back('{1,0,0, 1,0,1,6,0});
        tbl.push_back('{0,0,0, 0,1,0,1,0});
        tbl.push_back('{0,1,0, 0,0,0,1,0});
        tbl.push_back('{1,0,3, 9,0,0,1,0});
        tbl.push_back('{0,0,3, 0,1,1,2,1});
        tbl.push_back('{0,0,3, 0,0,1,2,1});
        tbl.push_back('{1,0,3, 9,0,1,2,1});
        tbl.push_back('{0,1,3, 0,0,1,2,0});
        tbl.push_back('{0,0,3, 0,0,1,2,0});

        // Reset held with random inputs.
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            x_is_valid = bit'($urandom_range(0, 1));
            flush = bit'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            x = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            chk("reset y_valid", 32'(y_valid), 0);
            chk("reset y", 32'(y), 0);
            chk("reset avg", 32'(avg), 0);
            chk("reset hits", 32'(hits), 0);
        end
        @(negedge clk);
        x_is_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].fl, tbl[i].md,
                 tbl[i].x, 4'd5);
            chk($sformatf("tbl[%0d] y_valid", i),
                32'(y_valid), 32'(tbl[i].eyv));
            chk($sformatf("tbl[%0d] y", i),
                32'(y), 32'(tbl[i].ey));
            chk($sformatf("tbl[%0d] avg", i),
                32'(avg), 32'(tbl[i].eavg));
            chk($sformatf("tbl[%0d] hits", i),
                32'(hits),
                STATS ? 32'(tbl[i].eh) : 32'd0);
        end

        // Randomized run with mode/threshold changes and mid-stream resets.
        begin
            logic [1:0] md;
            logic [3:0] th;
            md = 2'd0;
            th = 4'd5;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 49) == 0)
                    md = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 29) == 0)
                    th = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 399) == 0)
                    reset_pulse();
                else
                    step($urandom_range(0, 9) < 7,
                         $urandom_range(0, 39) == 0,
                         md,
                         4'($urandom_range(0, 15)),
                         th);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule

// File: doc/window_filter.md
# window_filter

Parametrised sliding-window sample filter, the next generation of the 4-bit `filters` block. It accepts a W-bit sample stream qualified by `x_is_valid` and keeps the last DEPTH samples. It computes a running sum and average, and raises a 1-bit decision `y` according to a run-time mode. It sits directly behind the sample source and feeds a registered flag plus window statistics to downstream control.

## Interface
- `W`, 4: sample width in bits.
- `DEPTH`, 4: window length in samples; power of two, 2..64.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `x_is_valid` input 1: sample qualifier; `x` is accepted on any rising edge where this is 1.
- `x` input W: sample, unsigned.
- `flush` input 1: synchronous window clear.
- `mode` input 2: decision mode.
- `thresh` input W: decision threshold, unsigned.
- `y` output 1: registered decision.
- `y_valid` output 1: one-cycle strobe marking a new decision.
- `avg` output W: window average.
- `hits` output 16: count of `y=1` decisions.

## Operation
- Let L = log2(DEPTH) and SW = W+L.
- `sum` is SW bits. On accept: `sum <= sum + x - oldest`. No overflow is possible.
- `avg` = `sum >> L`, truncating.
- `over_cnt` ($clog2(DEPTH+1) bits) counts the window samples with `x > thresh`. The comparison is evaluated at entry and stored per slot.
- State machine:
  - FILL: collecting samples; the fill counter runs 0..DEPTH-1. The DEPTH-th accept moves to RUN.
  - RUN: window full; every accept produces a decision.
- Reset and `flush` both enter FILL and zero the window, `sum`, `over_cnt`, fill counter and previous-decision register.
- `flush` and `x_is_valid` in the same cycle: flush wins and the sample is dropped.
- Decision modes, evaluated on the window including the newly accepted sample:
  - 00 AVG: `y = avg > thresh`.
  - 01 ALL: `y = (over_cnt == DEPTH)`.
  - 10 RISE: `y = (avg > thresh) && !prev`. `prev` holds the previous AVG result and is 0 after reset/flush.
  - 11 RAW: `y = x > thresh`. This mode is valid in FILL too and needs no full window.
- `mode` and `thresh` are sampled on each accept. A change does not flush the window. Stored per-slot comparisons keep their entry-time threshold.
- `x_is_valid` low: window, `y`, `avg` hold and `y_valid` is 0.

## Timing
- Reset values: `y=0`, `y_valid=0`, `avg=0`, `hits=0`, state FILL.
- Latency 1: a sample accepted at edge k updates the window. `y`, `avg` and `y_valid` are registered at edge k+1.
- `y_valid` is high for exactly one cycle per decision. Back-to-back valid samples give back-to-back strobes.
- `y` and `avg` hold their value until the next decision.
- First decision in modes 00/01/10 follows the DEPTH-th accept after reset/flush.
- Reset asserted mid-stream clears everything immediately. Any pending decision is lost and no strobe is emitted.
- A flush during the latency cycle suppresses the pending `y_valid`.

## Configuration
- `WINDOW_FILTER_STATS_EN` defined: `hits` increments on each `y_valid` with `y=1`. It saturates at 16'hFFFF and clears on reset and `flush`.
- Undefined: the counter logic is absent and `hits` is tied to 0. The port list is unchanged.

## Structure
- Package `window_filter_pkg` holds:
  - the `mode_t` enum (AVG, ALL, RISE, RAW);
  - the `state_t` enum (FILL, RUN);
  - the `HITS_W = 16` constant.
- Sub-module `window_filter_shreg` is the DEPTH-deep delay line of {sample, over-flag}. It has a shift enable and a synchronous clear, and exposes the oldest entry.
- The top level holds the FSM, the arithmetic and the output registers.

## Test plan
All scenarios use W=4, DEPTH=4, thresh=5.
1. Reset: hold `rst=0` with random inputs -> `y=0`, `y_valid=0`, `avg=0`, `hits=0`; no strobe after release until a full window.
2. Fill, mode 00: samples 5,7,4,8 -> no `y_valid` for the first three. After the 4th: `y_valid=1`, `avg=6` (sum 24), `y=1`.
3. Sliding, mode 00: continue with 15,0,0 -> avg 8 (y=1), 6 (y=1), 5 (y=0, since 5>5 is false). With the macro defined, `hits` ends at 3.
4. Mode 01: fill with 6,7,8,9 -> `y=1`. Next sample 5 -> `y=0`. Next 6 -> `y=0`; the window still holds the 5.
5. Mode 10: sample windows averaging 4, 6, 7, 3, 6 -> `y` = 0,1,0,0,1.
6. Gaps and flush:
   - Idle cycles between samples -> outputs hold and there are no strobes.
   - `flush` together with `x_is_valid` (x=9) -> sample dropped and state FILL. Four further accepts are needed before the next `y_valid`.
   - RAW mode in FILL: x=9 -> `y=1` one cycle later.
